sram_bw: RTL and testbench

Parametrised single-port synchronous SRAM model for the AHB SRAM controller subsystem. It is the next generation of the 8-bit 8K-deep bank and keeps the same active-low chip-select, write-enable and output-enable strobes. It adds configurable data width and depth, per-byte write masking, a 1- or 2-cycle read pipeline with a valid strobe, a selectable read-during-write mode, and a post-reset zero-fill sequencer. The controller instantiates one per bank and gates requests on `init_busy`.

---
 rtl/sram_bw_if.sv | 28 ++
 rtl/sram_bw.sv | 158 +++++++++++++++
 tb/tb_sram_bw.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bw_if.sv
// Request/response bundle between an SRAM controller bank port and one sram_bw instance.
// Strobes are active low; rdata/rvalid/init_busy flow back to the controller.
interface sram_bw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    localparam int NB = DATA_W / 8;

    logic              cs_n;
    logic              wen;
    logic              oen;
    logic [NB-1:0]     bwen_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              init_busy;

    modport master (
        output cs_n, wen, oen, bwen_n, addr, wdata,
        input  rdata, rvalid, init_busy
    );

    modport slave (
        input  cs_n, wen, oen, bwen_n, addr, wdata,
        output rdata, rvalid, init_busy
    );
endinterface

// File: rtl/sram_bw.sv
// Single-port SRAM bank with byte masks, zero-fill after reset and a 1/2-cycle read pipeline.
// Accepts one request per cycle, never stalls; requests are dropped while init_busy is high.
module sram_bw #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int INIT_EN  = 1
) (
    input  logic       clk,
    input  logic       rst,
    sram_bw_if.slave   bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              user_wr;
    logic              rd_req;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_wmask;

    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;

    // Fill sequencer: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign bus.init_busy = rst ? (INIT_EN != 0) : (state_q == ST_INIT);

    assign ready   = !rst && (state_q == ST_READY);
    assign user_wr = ready && !bus.cs_n && !bus.wen;
    assign rd_req  = ready && !bus.cs_n && !bus.oen && (bus.wen || (RDW_MODE == 1));

    // Read-during-write returns the post-write word, so merge the enabled lanes here.
    assign rd_old = mem[bus.addr];

    always_comb begin
        merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (!bus.bwen_n[i]) begin
                merged[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end

    assign rd_word = user_wr ? merged : rd_old;

    // One write port shared by the fill sequencer and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = bus.wdata;
        mem_wmask = ~bus.bwen_n;
        if (!rst && state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (user_wr) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_req;
            if (rd_req) begin
                s1_dat <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_vld;
            logic [DATA_W-1:0] s2_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign bus.rvalid = s2_vld;
            assign bus.rdata  = s2_dat;
        end else begin : g_lat1
            assign bus.rvalid = s1_vld;
            assign bus.rdata  = s1_dat;
        end
    endgenerate

endmodule

// File: tb/tb_sram_bw.sv
// Directed bench: two banks driven in lockstep, A = 1-cycle read / no RDW, B = 2-cycle read / write-through.
module tb_sram_bw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_bw_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    sram_bw_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    sram_bw #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .INIT_EN(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sram_bw #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1), .INIT_EN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic o, input logic [3:0] bw,
                         input logic [3:0] a, input logic [31:0] d);
        bus_a.cs_n = c; bus_a.wen = w; bus_a.oen = o; bus_a.bwen_n = bw; bus_a.addr = a; bus_a.wdata = d;
        bus_b.cs_n = c; bus_b.wen = w; bus_b.oen = o; bus_b.bwen_n = bw; bus_b.addr = a; bus_b.wdata = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bus_a.init_busy !== 1'b1 || bus_b.init_busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got a=%b b=%b want 1", bus_a.init_busy, bus_b.init_busy);
        end
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_b.rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got a=%b b=%b want 0", bus_a.rvalid, bus_b.rvalid);
        end
        checks++;
        if (bus_a.rdata !== 32'h0 || bus_b.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got a=%h b=%h want 0", bus_a.rdata, bus_b.rdata);
        end
    endtask

    task automatic test_fill();
        int n = 0;
        bit vld_seen = 0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'd2, 32'hDEADBEEF);
        rst = 1'b0;
        checks++;
        if (bus_a.init_busy !== 1'b1) begin
            errors++; $display("FAIL fill_busy_after_rst: got %b want 1", bus_a.init_busy);
        end
        while (bus_a.init_busy === 1'b1 && n < 100) begin
            cyc();
            n++;
            if (bus_a.rvalid !== 1'b0 || bus_b.rvalid !== 1'b0) vld_seen = 1;
        end
        idle();
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL fill_cycles: got %0d want 16", n);
        end
        checks++;
        if (vld_seen) begin
            errors++; $display("FAIL fill_no_rvalid: got rvalid during fill want none");
        end
        checks++;
        if (bus_b.init_busy !== 1'b0) begin
            errors++; $display("FAIL fill_busy_b: got %b want 0", bus_b.init_busy);
        end
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd2, 32'h0);
        cyc();
        idle();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'h0) begin
            errors++; $display("FAIL fill_ignored_write: got v=%b d=%h want v=1 d=00000000", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
    endtask

    task automatic test_read_all();
        int cnt_a = 0;
        int cnt_b = 0;
        int bad = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b0, 1'b1, 1'b0, 4'hF, 4'(i), 32'h0);
            else        idle();
            cyc();
            if (bus_a.rvalid === 1'b1) begin cnt_a++; if (bus_a.rdata !== 32'h0) bad++; end
            if (bus_b.rvalid === 1'b1) begin cnt_b++; if (bus_b.rdata !== 32'h0) bad++; end
        end
        checks++;
        if (cnt_a != 16 || cnt_b != 16) begin
            errors++; $display("FAIL read_all_pulses: got a=%0d b=%0d want 16", cnt_a, cnt_b);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL read_all_zero: got %0d nonzero words want 0", bad);
        end
    endtask

    task automatic test_byte_mask();
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'd3, 32'hA5A5A5A5);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 4'b1010, 4'd3, 32'h11223344);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd3, 32'h0);
        cyc();
        idle();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'hA522A544) begin
            errors++; $display("FAIL mask_a: got v=%b d=%h want v=1 d=a522a544", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
        checks++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 32'hA522A544) begin
            errors++; $display("FAIL mask_b: got v=%b d=%h want v=1 d=a522a544", bus_b.rvalid, bus_b.rdata);
        end
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'hA522A544) begin
            errors++; $display("FAIL mask_a_pulse: got v=%b d=%h want v=0 d=a522a544", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic        exp_av [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_ad [5] = '{32'h1, 32'h2, 32'h3, 32'h3, 32'h3};
        logic        exp_bv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_bd [5] = '{32'hA522A544, 32'h1, 32'h2, 32'h3, 32'h3};
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'h0, 4'(i), 32'(i));
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b0, 1'b1, 1'b0, 4'hF, 4'(i + 1), 32'h0);
            else       idle();
            cyc();
            checks++;
            if (bus_a.rvalid !== exp_av[i] || bus_a.rdata !== exp_ad[i]) begin
                errors++; $display("FAIL b2b_a[%0d]: got v=%b d=%h want v=%b d=%h", i, bus_a.rvalid, bus_a.rdata, exp_av[i], exp_ad[i]);
            end
            checks++;
            if (bus_b.rvalid !== exp_bv[i] || bus_b.rdata !== exp_bd[i]) begin
                errors++; $display("FAIL b2b_b[%0d]: got v=%b d=%h want v=%b d=%h", i, bus_b.rvalid, bus_b.rdata, exp_bv[i], exp_bd[i]);
            end
        end
    endtask

    task automatic test_rdw();
        drive(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 4'b1100, 4'd5, 32'h00000000);
        cyc();
        idle();
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'h3) begin
            errors++; $display("FAIL rdw0_hold: got v=%b d=%h want v=0 d=00000003", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
        checks++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 32'hFFFF0000) begin
            errors++; $display("FAIL rdw1_data: got v=%b d=%h want v=1 d=ffff0000", bus_b.rvalid, bus_b.rdata);
        end
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'h3) begin
            errors++; $display("FAIL rdw0_late: got v=%b d=%h want v=0 d=00000003", bus_a.rvalid, bus_a.rdata);
        end
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd5, 32'h0);
        cyc();
        idle();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'hFFFF0000) begin
            errors++; $display("FAIL rdw0_written: got v=%b d=%h want v=1 d=ffff0000", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
    endtask

    task automatic test_idle();
        bit vld_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'd5, 32'h12345678);
        cyc();
        if (bus_a.rvalid !== 1'b0 || bus_b.rvalid !== 1'b0) vld_seen = 1;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h0);
        cyc();
        if (bus_a.rvalid !== 1'b0 || bus_b.rvalid !== 1'b0) vld_seen = 1;
        idle();
        cyc();
        if (bus_a.rvalid !== 1'b0 || bus_b.rvalid !== 1'b0) vld_seen = 1;
        checks++;
        if (vld_seen) begin
            errors++; $display("FAIL idle_rvalid: got rvalid on idle cycles want none");
        end
        checks++;
        if (bus_a.rdata !== 32'hFFFF0000 || bus_b.rdata !== 32'hFFFF0000) begin
            errors++; $display("FAIL idle_hold: got a=%h b=%h want ffff0000", bus_a.rdata, bus_b.rdata);
        end
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd5, 32'h0);
        cyc();
        idle();
        cyc();
        checks++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 32'hFFFF0000) begin
            errors++; $display("FAIL idle_no_write: got v=%b d=%h want v=1 d=ffff0000", bus_b.rvalid, bus_b.rdata);
        end
        cyc();
    endtask

    task automatic test_reset_flush();
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd3, 32'h0);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        checks++;
        if (bus_b.rvalid !== 1'b0 || bus_b.rdata !== 32'h0) begin
            errors++; $display("FAIL flush_b: got v=%b d=%h want v=0 d=00000000", bus_b.rvalid, bus_b.rdata);
        end
        checks++;
        if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 32'h0) begin
            errors++; $display("FAIL flush_a: got v=%b d=%h want v=0 d=00000000", bus_a.rvalid, bus_a.rdata);
        end
    endtask

    task automatic test_fill_restart();
        int n = 0;
        rst = 1'b0;
        repeat (7) cyc();
        checks++;
        if (bus_a.init_busy !== 1'b1) begin
            errors++; $display("FAIL restart_mid: got %b want 1", bus_a.init_busy);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        while (bus_a.init_busy === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL restart_cycles: got %0d want 16", n);
        end
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd3, 32'h0);
        cyc();
        idle();
        checks++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 32'h0) begin
            errors++; $display("FAIL restart_zeroed: got v=%b d=%h want v=1 d=00000000", bus_a.rvalid, bus_a.rdata);
        end
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_read_all();
        test_byte_mask();
        test_back_to_back();
        test_rdw();
        test_idle();
        test_reset_flush();
        test_fill_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
